muldiv_iter: RTL and testbench
==============================

// Module: muldiv_iter
// PURPOSE
//  Multi-cycle RV64M execute unit: the parametrised successor of the single-cycle combinational mul/div.
//  Adds a valid/ready handshake, an iterative radix-2 divider, a counted multiplier, MULH* ops, RISC-V corner cases and flush.
//  Sits in the execute stage; the pipeline stalls while in_valid && !in_ready or while the result is not yet taken.
// PARAMETERS
//  XLEN        64  operand/result width; W ops work on the low XLEN/2 bits (XLEN even, >= 8)
//  MUL_CYCLES  2   cycles from accept to out_valid for mul ops (>= 1)
// PORTS
//  clk        in   1     clock
//  reset      in   1     synchronous, active-high reset
//  flush      in   1     abort any op in flight; drop the held result
//  in_valid   in   1     operands/op valid
//  in_ready   out  1     unit idle and able to accept
//  ia, ib     in   XLEN  rs1, rs2
//  mulOp      in   4     op code (see BEHAVIOUR)
//  out_valid  out  1     result valid; held until taken
//  out_ready  in   1     consumer takes the result
//  mulOut     out  XLEN  result
//  busy       out  1     state != IDLE
// BEHAVIOUR
//  Op codes: 0000 mul, 0001 mulh, 0010 mulhsu, 0011 mulhu, 0100 div, 0101 divu, 0110 rem, 0111 remu,
//   1000 mulw, 1100 divw, 1101 divuw, 1110 remw, 1111 remuw. Other codes: result 0, latency 1.
//  Reset: state IDLE, in_ready=1, out_valid=0, mulOut=0, busy=0. Iteration counter and operand regs are cleared.
//  Accept: at an edge where in_valid && in_ready. ia, ib and mulOp are latched. in_ready=0 from the next cycle.
//  FSM states: IDLE -> MUL | DIV | DONE, MUL -> DONE, DIV -> FIX -> DONE, DONE -> IDLE.
//   MUL: count MUL_CYCLES-1 further cycles, then register the product. out_valid is 1 at accept+MUL_CYCLES.
//   DIV: restoring shift/subtract, one quotient bit per cycle. N = XLEN iterations, or XLEN/2 for W ops.
//   FIX: apply the sign correction. out_valid is 1 at accept+N+2.
//   Special divides go IDLE -> DONE directly, with out_valid at accept+1:
//    divisor == 0: quotient = all ones; remainder = dividend.
//    signed overflow (dividend = most negative, divisor = -1): quotient = dividend; remainder = 0.
//   DONE: out_valid=1 and mulOut stable until out_ready. The edge with out_ready goes to IDLE; in_ready=1 in the next cycle.
//   No accept happens in the same cycle as the DONE handoff.
//  Arithmetic:
//   mul: low XLEN bits of the product.
//   mulh/mulhsu/mulhu: high XLEN bits of the 2*XLEN product of signed*signed, signed*unsigned and unsigned*unsigned operands.
//   div/rem: truncate toward zero; the remainder takes the sign of the dividend.
//   W ops: use [XLEN/2-1:0] of each operand (zero-extended for u variants, sign-extended otherwise).
//    The XLEN/2-bit result is sign-extended to XLEN (also for divuw/remuw).
//  flush: has priority over every other input in any state. Next state IDLE; out_valid=0 next cycle; in_ready=1 next cycle.
//   The result is discarded. If flush and in_valid are both high in IDLE, the op is NOT accepted.
//  reset mid-operation: same as the reset values; the partial quotient is lost.
//  out_ready while out_valid=0 is ignored. in_valid while busy is ignored (no queueing).
// STRUCTURE
//  common package: muldiv_op_t enum with the 4-bit codes above, MULDIV_FUNCT_W = 4, muldiv_state_t {IDLE, MUL, DIV, FIX, DONE}.
//  Sub-module div_iter_core(XLEN): magnitude restoring divider.
//   Ports: start, dividend, divisor, nbits -> done, quot, rem.
//   Sign handling, special cases and the W extension stay in muldiv_iter.
//  Multiplier: one 2*XLEN-bit product expression behind the MUL counter; no sub-module.
// TESTING
//  1 mul ia=7 ib=-3 (XLEN=64) -> mulOut=-21 at accept+2; mulhu ia=ib=2^64-1 -> 0xFFFFFFFFFFFFFFFE.
//  2 div ia=-7 ib=2 -> mulOut=-3 at accept+66; rem with the same operands -> -1.
//    divuw ia=0x1_FFFFFFFF ib=1 -> 0xFFFFFFFFFFFFFFFF at accept+34.
//  3 div ib=0, ia=5 -> mulOut=0xFFFFFFFFFFFFFFFF at accept+1; remu ib=0 ia=5 -> 5.
//    div ia=0x8000000000000000 ib=-1 -> 0x8000000000000000; rem with the same operands -> 0.
//  4 divw ia=0x80000000 ib=0xFFFFFFFF -> 0xFFFFFFFF80000000; remw with the same operands -> 0.
//  5 Backpressure: out_ready=0 for 5 cycles after out_valid -> mulOut stable, in_ready=0; out_ready=1 -> in_ready=1 next cycle.
//  6 flush at iteration 10 of a div -> out_valid never asserts; in_ready=1 next cycle; a following mul returns the correct result.
//    reset at the same point gives the same outcome.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared op codes, FSM states and op-class helpers for the iterative RV64M mul/div unit.
package muldiv_pkg;

  localparam int unsigned MULDIV_FUNCT_W = 4;

  typedef enum logic [MULDIV_FUNCT_W-1:0] {
    OP_MUL    = 4'b0000,
    OP_MULH   = 4'b0001,
    OP_MULHSU = 4'b0010,
    OP_MULHU  = 4'b0011,
    OP_DIV    = 4'b0100,
    OP_DIVU   = 4'b0101,
    OP_REM    = 4'b0110,
    OP_REMU   = 4'b0111,
    OP_MULW   = 4'b1000,
    OP_DIVW   = 4'b1100,
    OP_DIVUW  = 4'b1101,
    OP_REMW   = 4'b1110,
    OP_REMUW  = 4'b1111
  } muldiv_op_t;

  typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} muldiv_state_t;

  function automatic logic isMulOp(input logic [MULDIV_FUNCT_W-1:0] op);
    return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_MULW};
  endfunction

  // Every divide/remainder code has bit 2 set; no multiply code does.
  function automatic logic isDivOp(input logic [MULDIV_FUNCT_W-1:0] op);
    return op[2];
  endfunction

endpackage

// File: rtl/div_iter_core.sv
// Unsigned restoring divider: one quotient bit per clock, nbits iterations.
// The first iteration happens on the start edge; done pulses the cycle after the last one.
module div_iter_core #(
  parameter  int unsigned XLEN  = 64,
  localparam int unsigned CNT_W = $clog2(XLEN + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [XLEN-1:0]  dividend,
  input  logic [XLEN-1:0]  divisor,
  input  logic [CNT_W-1:0] nbits,
  output logic             done,
  output logic [XLEN-1:0]  quot,
  output logic [XLEN-1:0]  rem
);

  logic [XLEN-1:0]  remR, qR, divR;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] shiftAmt;
  logic [XLEN-1:0]  srcRem, srcQ, srcDiv, stepRem, stepQ;
  logic [XLEN:0]    partial, diff;
  logic             fits, active;

  // Short dividends are pre-shifted so their MSB enters first and the quotient lands in the low bits.
  always_comb begin
    shiftAmt = CNT_W'(XLEN) - nbits;
    srcRem   = start ? '0 : remR;
    srcQ     = start ? (dividend << shiftAmt) : qR;
    srcDiv   = start ? divisor : divR;
    partial  = {srcRem, srcQ[XLEN-1]};
    diff     = partial - {1'b0, srcDiv};
    fits     = !diff[XLEN];
    stepRem  = fits ? diff[XLEN-1:0] : partial[XLEN-1:0];
    stepQ    = {srcQ[XLEN-2:0], fits};
    active   = start || (cnt != '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      remR <= '0;
      qR   <= '0;
      divR <= '0;
      cnt  <= '0;
      done <= 1'b0;
    end else if (active) begin
      remR <= stepRem;
      qR   <= stepQ;
      divR <= srcDiv;
      cnt  <= start ? (nbits - CNT_W'(1)) : (cnt - CNT_W'(1));
      done <= !start && (cnt == CNT_W'(1));
    end else begin
      done <= 1'b0;
    end
  end

  assign quot = qR;
  assign rem  = remR;

endmodule

// File: rtl/muldiv_iter.sv
// Multi-cycle RV64M execute unit: counted multiplier, iterative divider, valid/ready handshake and flush.
module muldiv_iter
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN       = 64,
  parameter int unsigned MUL_CYCLES = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [XLEN-1:0]           ia,
  input  logic [XLEN-1:0]           ib,
  input  logic [MULDIV_FUNCT_W-1:0] mulOp,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [XLEN-1:0]           mulOut,
  output logic                      busy
);

  localparam int unsigned HALF   = XLEN / 2;
  localparam int unsigned CNT_W  = $clog2(XLEN + 1);
  localparam int unsigned MCNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [XLEN-1:0] MIN_FULL = XLEN'(1) << (XLEN - 1);
  localparam logic [HALF-1:0] MIN_HALF = HALF'(1) << (HALF - 1);

  muldiv_state_t             state, nextState;
  logic [XLEN-1:0]           aR, bR;
  logic [MULDIV_FUNCT_W-1:0] opR;
  logic [MCNT_W-1:0]         mulCnt;
  logic                      accept, divStart, divDone, loadRes;
  logic [XLEN-1:0]           resNext, coreQuot, coreRem;

  function automatic logic [XLEN-1:0] wExt(input logic [HALF-1:0] v);
    return {{HALF{v[HALF-1]}}, v};
  endfunction

  function automatic logic [XLEN-1:0] opndExt(input logic [XLEN-1:0] v, input logic isW,
                                             input logic isUns);
    if (!isW) return v;
    return isUns ? {{HALF{1'b0}}, v[HALF-1:0]} : wExt(v[HALF-1:0]);
  endfunction

  assign accept = (state == IDLE) && in_valid && !flush;

  // Multiplier: live operands when finishing straight from IDLE, latched ones otherwise.
  logic [XLEN-1:0]           selA, selB, mulRes;
  logic [MULDIV_FUNCT_W-1:0] selOp;
  logic                      aSig, bSig;
  logic [2*XLEN-1:0]         product;

  always_comb begin
    selA    = (state == IDLE) ? ia : aR;
    selB    = (state == IDLE) ? ib : bR;
    selOp   = (state == IDLE) ? mulOp : opR;
    aSig    = (selOp == OP_MULH) || (selOp == OP_MULHSU);
    bSig    = (selOp == OP_MULH);
    product = {{XLEN{aSig & selA[XLEN-1]}}, selA} * {{XLEN{bSig & selB[XLEN-1]}}, selB};
    case (selOp)
      OP_MULH, OP_MULHSU, OP_MULHU: mulRes = product[2*XLEN-1:XLEN];
      OP_MULW:                      mulRes = wExt(product[HALF-1:0]);
      default:                      mulRes = product[XLEN-1:0];
    endcase
  end

  // Divide set-up from the live operands at accept: magnitudes and the two short-cut cases.
  logic            inW, inUns, inRem, inZero, inOvf, inANeg, inBNeg;
  logic [XLEN-1:0] inA, inB, magA, magB, specialRes;
  logic [CNT_W-1:0] nbits;

  always_comb begin
    inW    = mulOp[3];
    inUns  = mulOp[0];
    inRem  = mulOp[1];
    inA    = opndExt(ia, inW, inUns);
    inB    = opndExt(ib, inW, inUns);
    inZero = (inB == '0);
    inOvf  = !inUns && (inW ? ((ia[HALF-1:0] == MIN_HALF) && (ib[HALF-1:0] == '1))
                            : ((ia == MIN_FULL) && (ib == '1)));
    inANeg = !inUns && inA[XLEN-1];
    inBNeg = !inUns && inB[XLEN-1];
    magA   = inANeg ? -inA : inA;
    magB   = inBNeg ? -inB : inB;
    nbits  = inW ? CNT_W'(HALF) : CNT_W'(XLEN);
    if (inZero) specialRes = inRem ? inA : '1;
    else        specialRes = inRem ? '0 : inA;
    if (inW) specialRes = wExt(specialRes[HALF-1:0]);
  end

  div_iter_core #(.XLEN(XLEN)) uDiv (
    .clk      (clk),
    .reset    (reset),
    .start    (divStart),
    .dividend (magA),
    .divisor  (magB),
    .nbits    (nbits),
    .done     (divDone),
    .quot     (coreQuot),
    .rem      (coreRem)
  );

  // Sign correction of the magnitude result; remainder follows the dividend's sign.
  logic            fW, fUns, fRem, fANeg, fBNeg;
  logic [XLEN-1:0] fixRes;

  always_comb begin
    fW    = opR[3];
    fUns  = opR[0];
    fRem  = opR[1];
    fANeg = !fUns && (fW ? aR[HALF-1] : aR[XLEN-1]);
    fBNeg = !fUns && (fW ? bR[HALF-1] : bR[XLEN-1]);
    if (fRem) fixRes = fANeg ? -coreRem : coreRem;
    else      fixRes = (fANeg ^ fBNeg) ? -coreQuot : coreQuot;
    if (fW) fixRes = wExt(fixRes[HALF-1:0]);
  end

  always_comb begin
    nextState = state;
    loadRes   = 1'b0;
    resNext   = '0;
    divStart  = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          if (isMulOp(mulOp)) begin
            if (MUL_CYCLES == 1) begin
              nextState = DONE;
              loadRes   = 1'b1;
              resNext   = mulRes;
            end else begin
              nextState = MUL;
            end
          end else if (isDivOp(mulOp)) begin
            if (inZero || inOvf) begin
              nextState = DONE;
              loadRes   = 1'b1;
              resNext   = specialRes;
            end else begin
              nextState = DIV;
              divStart  = 1'b1;
            end
          end else begin
            nextState = DONE;
            loadRes   = 1'b1;
          end
        end
      end
      MUL: begin
        if (mulCnt == '0) begin
          nextState = DONE;
          loadRes   = 1'b1;
          resNext   = mulRes;
        end
      end
      DIV: begin
        if (divDone) nextState = FIX;
      end
      FIX: begin
        nextState = DONE;
        loadRes   = 1'b1;
        resNext   = fixRes;
      end
      DONE: begin
        if (out_ready) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
    if (flush) begin
      nextState = IDLE;
      loadRes   = 1'b0;
      divStart  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  // Handshake flags are registered copies of the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      aR        <= '0;
      bR        <= '0;
      opR       <= '0;
      mulCnt    <= '0;
      mulOut    <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      in_ready  <= (nextState == IDLE);
      out_valid <= (nextState == DONE);
      busy      <= (nextState != IDLE);
      if (accept) begin
        aR     <= ia;
        bR     <= ib;
        opR    <= mulOp;
        mulCnt <= MCNT_W'(MUL_CYCLES - 2);
      end else if ((state == MUL) && (mulCnt != '0)) begin
        mulCnt <= mulCnt - MCNT_W'(1);
      end
      if (flush)        mulOut <= '0;
      else if (loadRes) mulOut <= resNext;
    end
  end

endmodule

// File: tb/tb_muldiv_iter.sv
// Self-checking bench for muldiv_iter: directed RV64M corner cases plus randomized ops against an arithmetic model.
module tb_muldiv_iter;

  localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;

  typedef struct {
    logic [3:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready, out_valid, out_ready, busy;
  logic [63:0] ia, ib, mulOut;
  logic [3:0]  mulOp;
  int          passCnt = 0;
  int          totalCnt = 0;

  always #5 clk = ~clk;

  muldiv_iter #(.XLEN(64), .MUL_CYCLES(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ia        (ia),
    .ib        (ib),
    .mulOp     (mulOp),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .mulOut    (mulOut),
    .busy      (busy)
  );

  // Reference result straight from the RISC-V M-extension arithmetic rules.
  function automatic logic [63:0] refModel(input logic [3:0] op, input logic [63:0] a,
                                           input logic [63:0] b);
    logic signed [127:0] p;
    longint              sa, sb;
    int                  sa32, sb32;
    logic [31:0]         ua32, ub32, r32;
    logic [63:0]         r;
    logic                ovf64, ovf32;
    sa = a; sb = b; sa32 = a[31:0]; sb32 = b[31:0]; ua32 = a[31:0]; ub32 = b[31:0];
    ovf64 = (a == MIN64) && (b == 64'hFFFF_FFFF_FFFF_FFFF);
    ovf32 = (ua32 == 32'h8000_0000) && (ub32 == 32'hFFFF_FFFF);
    r = '0; r32 = '0;
    case (op)
      4'd0: r = a * b;
      4'd1: begin p = $signed({{64{a[63]}}, a}) * $signed({{64{b[63]}}, b}); r = p[127:64]; end
      4'd2: begin p = $signed({{64{a[63]}}, a}) * $signed({64'd0, b}); r = p[127:64]; end
      4'd3: begin p = $signed({64'd0, a}) * $signed({64'd0, b}); r = p[127:64]; end
      4'd4: r = (b == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : ovf64 ? a : 64'(sa / sb);
      4'd5: r = (b == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : a / b;
      4'd6: r = (b == 0) ? a : ovf64 ? 64'd0 : 64'(sa % sb);
      4'd7: r = (b == 0) ? a : a % b;
      4'd8:  r32 = ua32 * ub32;
      4'd12: r32 = (ub32 == 0) ? 32'hFFFF_FFFF : ovf32 ? ua32 : 32'(sa32 / sb32);
      4'd13: r32 = (ub32 == 0) ? 32'hFFFF_FFFF : ua32 / ub32;
      4'd14: r32 = (ub32 == 0) ? ua32 : ovf32 ? 32'd0 : 32'(sa32 % sb32);
      4'd15: r32 = (ub32 == 0) ? ua32 : ua32 % ub32;
      default: r = '0;
    endcase
    if (op[3]) r = {{32{r32[31]}}, r32};
    return r;
  endfunction

  // Cycles from accept to out_valid for a given op and operands.
  function automatic int refLat(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    logic zero, ovf;
    if (op inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd8}) return 2;
    if (!op[2]) return 1;
    zero = op[3] ? (b[31:0] == 0) : (b == 0);
    ovf  = !op[0] && (op[3] ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                            : (a == MIN64 && b == 64'hFFFF_FFFF_FFFF_FFFF));
    if (zero || ovf) return 1;
    return op[3] ? 34 : 66;
  endfunction

  function automatic logic [63:0] pickOperand();
    case ($urandom_range(0, 7))
      0: return 64'd0;
      1: return 64'hFFFF_FFFF_FFFF_FFFF;
      2: return MIN64;
      3: return 64'h0000_0000_8000_0000;
      4: return 64'h0000_0000_FFFF_FFFF;
      5: return 64'($urandom_range(0, 40)) - 64'd20;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // Issue one op, measure accept-to-valid latency, then take the result.
  task automatic runOp(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                       output logic [63:0] res, output int lat);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    in_valid = 1'b1; mulOp = op; ia = a; ib = b;
    @(posedge clk); #1;
    in_valid = 1'b0; ia = {$urandom, $urandom}; ib = {$urandom, $urandom}; mulOp = 4'($urandom);
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    res = mulOut;
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    totalCnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready); else passCnt++;
    totalCnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid); else passCnt++;
    totalCnt++; if (mulOut !== 64'd0) $display("FAIL reset_mulOut: got %h expected 0", mulOut); else passCnt++;
    totalCnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passCnt++;
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_directed();
    vec_t        v[11];
    logic [63:0] res;
    int          lat;
    v[0]  = '{4'd0,  64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 2};
    v[1]  = '{4'd3,  64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 2};
    v[2]  = '{4'd4,  64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 66};
    v[3]  = '{4'd6,  64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 66};
    v[4]  = '{4'd13, 64'h0000_0001_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 34};
    v[5]  = '{4'd4,  64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1};
    v[6]  = '{4'd7,  64'd5, 64'd0, 64'd5, 1};
    v[7]  = '{4'd4,  MIN64, 64'hFFFF_FFFF_FFFF_FFFF, MIN64, 1};
    v[8]  = '{4'd6,  MIN64, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1};
    v[9]  = '{4'd12, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1};
    v[10] = '{4'd14, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'd0, 1};
    foreach (v[i]) begin
      runOp(v[i].op, v[i].a, v[i].b, res, lat);
      totalCnt++;
      if (res !== v[i].exp) $display("FAIL directed_%0d_result op=%0d: got %h expected %h", i, v[i].op, res, v[i].exp);
      else passCnt++;
      totalCnt++;
      if (lat !== v[i].lat) $display("FAIL directed_%0d_latency op=%0d: got %0d expected %0d", i, v[i].op, lat, v[i].lat);
      else passCnt++;
    end
  endtask

  task automatic test_random();
    logic [3:0]  ops[16];
    logic [63:0] a, b, res, expRes;
    int          lat, expLat;
    logic [3:0]  op;
    ops = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7,
            4'd8, 4'd12, 4'd13, 4'd14, 4'd15, 4'd9, 4'd10, 4'd11};
    for (int n = 0; n < 48; n++) begin
      op = ops[$urandom_range(0, 15)];
      a = pickOperand();
      b = pickOperand();
      expRes = refModel(op, a, b);
      expLat = refLat(op, a, b);
      runOp(op, a, b, res, lat);
      totalCnt++;
      if (res !== expRes) $display("FAIL random_result op=%0d a=%h b=%h: got %h expected %h", op, a, b, res, expRes);
      else passCnt++;
      totalCnt++;
      if (lat !== expLat) $display("FAIL random_latency op=%0d: got %0d expected %0d", op, lat, expLat);
      else passCnt++;
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] held;
    int          guard;
    @(negedge clk);
    in_valid = 1'b1; mulOp = 4'd0; ia = 64'd6; ib = 64'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    guard = 0;
    while (!out_valid && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    held = mulOut;
    totalCnt++; if (held !== 64'd42) $display("FAIL bp_result: got %h expected %h", held, 64'd42); else passCnt++;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      in_valid = 1'b1; mulOp = 4'd0; ia = {$urandom, $urandom}; ib = 64'd3;
      @(posedge clk); #1;
      totalCnt++; if (mulOut !== held || out_valid !== 1'b1) $display("FAIL bp_hold_%0d: got %h/%b expected %h/1", c, mulOut, out_valid, held); else passCnt++;
      totalCnt++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready_%0d: got %b expected 0", c, in_ready); else passCnt++;
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    totalCnt++; if (in_ready !== 1'b1) $display("FAIL bp_release_in_ready: got %b expected 1", in_ready); else passCnt++;
    totalCnt++; if (out_valid !== 1'b0) $display("FAIL bp_release_out_valid: got %b expected 0", out_valid); else passCnt++;
    repeat (4) @(posedge clk);
    #1;
    totalCnt++; if (out_valid !== 1'b0 || busy !== 1'b0) $display("FAIL bp_no_queue: got valid=%b busy=%b expected 0/0", out_valid, busy); else passCnt++;
  endtask

  // Abort a divide at iteration 10 with flush (useReset=0) or reset (useReset=1).
  task automatic test_abort(input bit useReset);
    logic [63:0] res;
    int          lat;
    bit          sawValid;
    @(negedge clk);
    in_valid = 1'b1; mulOp = 4'd4; ia = 64'd1000; ib = 64'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    if (useReset) reset = 1'b1; else flush = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; flush = 1'b0;
    totalCnt++; if (out_valid !== 1'b0) $display("FAIL abort%0d_out_valid: got %b expected 0", useReset, out_valid); else passCnt++;
    totalCnt++; if (in_ready !== 1'b1) $display("FAIL abort%0d_in_ready: got %b expected 1", useReset, in_ready); else passCnt++;
    totalCnt++; if (busy !== 1'b0) $display("FAIL abort%0d_busy: got %b expected 0", useReset, busy); else passCnt++;
    sawValid = 1'b0;
    repeat (80) begin
      @(posedge clk); #1;
      if (out_valid) sawValid = 1'b1;
    end
    totalCnt++; if (sawValid !== 1'b0) $display("FAIL abort%0d_stale_valid: got %b expected 0", useReset, sawValid); else passCnt++;
    runOp(4'd0, 64'd123, 64'hFFFF_FFFF_FFFF_FFFB, res, lat);
    totalCnt++; if (res !== 64'hFFFF_FFFF_FFFF_FD99) $display("FAIL abort%0d_next_mul: got %h expected %h", useReset, res, 64'hFFFF_FFFF_FFFF_FD99); else passCnt++;
    totalCnt++; if (lat !== 2) $display("FAIL abort%0d_next_latency: got %0d expected 2", useReset, lat); else passCnt++;
  endtask

  task automatic test_flush_edges();
    int guard;
    // flush together with in_valid in IDLE: not accepted
    @(negedge clk);
    in_valid = 1'b1; flush = 1'b1; mulOp = 4'd0; ia = 64'd9; ib = 64'd9;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    totalCnt++; if (in_ready !== 1'b1) $display("FAIL flush_idle_in_ready: got %b expected 1", in_ready); else passCnt++;
    repeat (3) @(posedge clk);
    #1;
    totalCnt++; if (out_valid !== 1'b0) $display("FAIL flush_idle_out_valid: got %b expected 0", out_valid); else passCnt++;
    // flush while a result is held drops it
    @(negedge clk);
    in_valid = 1'b1; mulOp = 4'd0; ia = 64'd9; ib = 64'd9;
    @(posedge clk); #1;
    in_valid = 1'b0;
    guard = 0;
    while (!out_valid && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    totalCnt++; if (mulOut !== 64'd81) $display("FAIL flush_done_result: got %h expected %h", mulOut, 64'd81); else passCnt++;
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    totalCnt++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL flush_done_drop: got valid=%b ready=%b expected 0/1", out_valid, in_ready); else passCnt++;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    ia = '0; ib = '0; mulOp = '0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_abort(1'b0);
    test_abort(1'b1);
    test_flush_edges();
    test_random();
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish, %0d of %0d checks passed", passCnt, totalCnt);
    $fatal(1);
  end

endmodule
